alu_decode_stage: RTL and testbench

- Registered, parametrised ALU decode stage for the processor datapath.
- Converts cmd/S/ALUOp into an ALU opcode, a flag-write mask and a NoWrite flag, using a wider opcode set.
- Holds the NZCV flag register, evaluates the ARM condition field, and gates register and memory writes.
- Sits between instruction decode and execute, with a valid/ready handshake on each side.

---
 rtl/alu_decode_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered ALU decode stage with NZCV flag register,
// ARM condition evaluation and write gating, valid/ready on both sides.
// Optional illegal-instruction trap is enabled by defining ALU_DECODE_TRAP_EN.
module alu_decode_stage #(
    parameter int unsigned CTRL_W = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        cmd,
    input  logic              S,
    input  logic              ALUOp,
    input  logic [3:0]        cond,
    input  logic              reg_write_in,
    input  logic              mem_write_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ALUControl,
    output logic [1:0]        FlagW,
    output logic              NoWrite,
    output logic              reg_write_out,
    output logic              mem_write_out,
    output logic              cond_ex,
    input  logic [3:0]        alu_flags,
    output logic [3:0]        flags,
    output logic [CNT_W-1:0]  illegal_cnt
`ifdef ALU_DECODE_TRAP_EN
    ,
    output logic              trap,
    input  logic              trap_clr
`endif
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_ORR = 3'd3;
    localparam logic [2:0] OP_EOR = 3'd4;
    localparam logic [2:0] OP_MOV = 3'd5;
    // A 2-bit opcode cannot encode EOR/MOV, so they become illegal.
    localparam bit NARROW = (CTRL_W < 3);

`ifdef ALU_DECODE_TRAP_EN
    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, TRAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1} state_t;
`endif

    state_t     state_q;
    state_t     state_d;
    logic       accept;
    logic [2:0] dec_op;
    logic [1:0] dec_flagw;
    logic       dec_nowrite;
    logic       dec_cmp;
    logic       dec_arith;
    logic       dec_illegal;
    logic [3:0] cond_r;
    logic       reg_write_r;
    logic       mem_write_r;
    logic       flag_upd;
`ifdef ALU_DECODE_TRAP_EN
    logic       illegal_r;
`endif

    // Decode cmd/S/ALUOp into opcode, flag mask, NoWrite and legality.
    always_comb begin
        dec_op      = OP_ADD;
        dec_cmp     = 1'b0;
        dec_arith   = 1'b1;
        dec_illegal = 1'b0;
        dec_flagw   = 2'b00;
        if (ALUOp) begin
            case (cmd)
                4'b0100: dec_op = OP_ADD;
                4'b0010: dec_op = OP_SUB;
                4'b0000: begin dec_op = OP_AND; dec_arith = 1'b0; end
                4'b1100: begin dec_op = OP_ORR; dec_arith = 1'b0; end
                4'b0001: begin dec_op = OP_EOR; dec_arith = 1'b0; end
                4'b1101: begin dec_op = OP_MOV; dec_arith = 1'b0; end
                4'b1010: begin dec_op = OP_SUB; dec_cmp = 1'b1; end
                4'b1011: begin dec_op = OP_ADD; dec_cmp = 1'b1; end
                4'b1000: begin dec_op = OP_AND; dec_cmp = 1'b1; dec_arith = 1'b0; end
                default: dec_illegal = 1'b1;
            endcase
            if (dec_cmp && !S) begin
                dec_illegal = 1'b1;
            end
            if (NARROW && dec_op[2]) begin
                dec_illegal = 1'b1;
            end
            if (S) begin
                dec_flagw = dec_arith ? 2'b11 : 2'b10;
            end
        end
        dec_nowrite = dec_cmp;
        if (dec_illegal) begin
            dec_op      = OP_ADD;
            dec_flagw   = 2'b00;
            dec_nowrite = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake logic.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                in_ready = out_ready;
`ifdef ALU_DECODE_TRAP_EN
                if (illegal_r) begin
                    in_ready = 1'b0;
                end
`endif
                if (out_ready) begin
                    state_d = (in_valid && in_ready) ? FULL : EMPTY;
                end
`ifdef ALU_DECODE_TRAP_EN
                if (out_ready && illegal_r) begin
                    state_d = TRAP;
                end
`endif
            end
`ifdef ALU_DECODE_TRAP_EN
            TRAP: begin
                if (trap_clr) begin
                    state_d = EMPTY;
                end
            end
`endif
            default: state_d = EMPTY;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == FULL);
`ifdef ALU_DECODE_TRAP_EN
    assign trap      = (state_q == TRAP);
`endif

    // Capture the decoded request on acceptance; hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUControl  <= '0;
            FlagW       <= 2'b00;
            NoWrite     <= 1'b0;
            cond_r      <= 4'b0000;
            reg_write_r <= 1'b0;
            mem_write_r <= 1'b0;
`ifdef ALU_DECODE_TRAP_EN
            illegal_r   <= 1'b0;
`endif
        end else if (accept) begin
            ALUControl  <= CTRL_W'(dec_op);
            FlagW       <= dec_flagw;
            NoWrite     <= dec_nowrite;
            cond_r      <= cond;
            reg_write_r <= reg_write_in & ~dec_illegal;
            mem_write_r <= mem_write_in & ~dec_illegal;
`ifdef ALU_DECODE_TRAP_EN
            illegal_r   <= dec_illegal;
`endif
        end
    end

    // ARM condition evaluation against the architectural flags.
    always_comb begin
        cond_ex = 1'b0;
        case (cond_r)
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = ~flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = ~flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = ~flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = ~flags[0];
            4'b1000: cond_ex = flags[1] & ~flags[2];
            4'b1001: cond_ex = ~flags[1] | flags[2];
            4'b1010: cond_ex = (flags[3] == flags[0]);
            4'b1011: cond_ex = (flags[3] != flags[0]);
            4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign reg_write_out = out_valid & cond_ex & reg_write_r & ~NoWrite;
    assign mem_write_out = out_valid & cond_ex & mem_write_r;
    assign flag_upd      = out_valid & out_ready & cond_ex;

    // NZCV register; new flags become visible the cycle after consumption.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if (flag_upd) begin
            if (FlagW[1]) begin
                flags[3:2] <= alu_flags[3:2];
            end
            if (FlagW[0]) begin
                flags[1:0] <= alu_flags[1:0];
            end
        end
    end

    // Saturating count of accepted illegal requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (accept && dec_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage (default build).
module tb_alu_decode_stage;

    localparam int unsigned CTRL_W  = 3;
    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        cmd;
    logic              S;
    logic              ALUOp;
    logic [3:0]        cond;
    logic              reg_write_in;
    logic              mem_write_in;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] ALUControl;
    logic [1:0]        FlagW;
    logic              NoWrite;
    logic              reg_write_out;
    logic              mem_write_out;
    logic              cond_ex;
    logic [3:0]        alu_flags;
    logic [3:0]        flags;
    logic [CNT_W-1:0]  illegal_cnt;
`ifdef ALU_DECODE_TRAP_EN
    logic              trap;
    logic              trap_clr;
`endif

    alu_decode_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .cmd(cmd), .S(S), .ALUOp(ALUOp), .cond(cond),
        .reg_write_in(reg_write_in), .mem_write_in(mem_write_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUControl(ALUControl), .FlagW(FlagW), .NoWrite(NoWrite),
        .reg_write_out(reg_write_out), .mem_write_out(mem_write_out),
        .cond_ex(cond_ex), .alu_flags(alu_flags), .flags(flags),
        .illegal_cnt(illegal_cnt)
`ifdef ALU_DECODE_TRAP_EN
        , .trap(trap), .trap_clr(trap_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ctrl;
        logic [1:0] flagw;
        logic       nowrite;
        logic       rw;
        logic       mw;
        logic [3:0] cnd;
        logic       illegal;
    } exp_t;

    exp_t       sb[$];
    int         n_checks;
    int         n_fail;
    logic [3:0] m_flags;
    int         m_cnt;
    bit         m_full;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_decode(input bit aluop, input logic [3:0] c, input bit s,
                                          input logic [3:0] cd, input bit rw, input bit mw);
        exp_t e;
        bit   arith;
        e.cnd = cd; e.ctrl = 3'd0; e.flagw = 2'b00; e.nowrite = 1'b0;
        e.illegal = 1'b0; e.rw = rw; e.mw = mw;
        arith = 1'b0;
        if (aluop) begin
            case (c)
                4'b0100: begin e.ctrl = 3'd0; arith = 1'b1; end
                4'b0010: begin e.ctrl = 3'd1; arith = 1'b1; end
                4'b0000: e.ctrl = 3'd2;
                4'b1100: e.ctrl = 3'd3;
                4'b0001: e.ctrl = 3'd4;
                4'b1101: e.ctrl = 3'd5;
                4'b1010: begin e.ctrl = 3'd1; arith = 1'b1; e.nowrite = 1'b1; e.illegal = !s; end
                4'b1011: begin e.ctrl = 3'd0; arith = 1'b1; e.nowrite = 1'b1; e.illegal = !s; end
                4'b1000: begin e.ctrl = 3'd2; e.nowrite = 1'b1; e.illegal = !s; end
                default: e.illegal = 1'b1;
            endcase
            if (s) e.flagw = arith ? 2'b11 : 2'b10;
        end
        if (e.illegal) begin
            e.ctrl = 3'd0; e.flagw = 2'b00; e.nowrite = 1'b1; e.rw = 1'b0; e.mw = 1'b0;
        end
        return e;
    endfunction

    function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // One clock cycle: drive at negedge, check #1 later, update model, wait for next negedge.
    task automatic step(input bit iv, input bit aluop, input logic [3:0] c, input bit s,
                        input logic [3:0] cd, input bit rw, input bit mw,
                        input bit ordy, input logic [3:0] af);
        exp_t e;
        exp_t n;
        bit   exp_rdy, ce, consume, acc;
        in_valid = iv; ALUOp = aluop; cmd = c; S = s; cond = cd;
        reg_write_in = rw; mem_write_in = mw; out_ready = ordy; alu_flags = af;
        #1;
        exp_rdy = !m_full || ordy;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_full));
        check("flags", 32'(flags), 32'(m_flags));
        check("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
        ce = 1'b0;
        e  = '{default: '0};
        if (m_full) begin
            check("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() != 0) begin
                e  = sb[0];
                ce = model_cond(e.cnd, m_flags);
                check("ALUControl", 32'(ALUControl), 32'(e.ctrl));
                check("FlagW", 32'(FlagW), 32'(e.flagw));
                check("NoWrite", 32'(NoWrite), 32'(e.nowrite));
                check("cond_ex", 32'(cond_ex), 32'(ce));
                check("reg_write_out", 32'(reg_write_out), 32'(ce && e.rw && !e.nowrite));
                check("mem_write_out", 32'(mem_write_out), 32'(ce && e.mw));
            end
        end else begin
            check("reg_write_idle", 32'(reg_write_out), 32'd0);
            check("mem_write_idle", 32'(mem_write_out), 32'd0);
        end
        consume = m_full && ordy;
        acc     = iv && exp_rdy;
        if (consume && sb.size() != 0) begin
            void'(sb.pop_front());
            if (ce) begin
                if (e.flagw[1]) m_flags[3:2] = af[3:2];
                if (e.flagw[0]) m_flags[1:0] = af[1:0];
            end
        end
        if (acc) begin
            n = model_decode(aluop, c, s, cd, rw, mw);
            sb.push_back(n);
            if (n.illegal && m_cnt < CNT_MAX) m_cnt++;
        end
        m_full = acc || (m_full && !ordy);
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 1'b0, 4'd0, 1'b0, 4'd14, 1'b0, 1'b0, ordy, 4'd0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_flags = 4'b0000; m_cnt = 0; m_full = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0; ALUOp = 1'b0; cmd = 4'd0; S = 1'b0; cond = 4'd14;
        reg_write_in = 1'b0; mem_write_in = 1'b0; out_ready = 1'b0; alu_flags = 4'd0;
`ifdef ALU_DECODE_TRAP_EN
        trap_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ALUControl", 32'(ALUControl), 32'd0);
        check("rst_FlagW", 32'(FlagW), 32'd0);
        check("rst_NoWrite", 32'(NoWrite), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD, S=0
        step(1'b1, 1'b1, 4'b0100, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b1, 4'd0);
        check("add_ctrl", 32'(ALUControl), 32'd0);
        check("add_valid", 32'(out_valid), 32'd1);
        idle(1'b1);

        // CMP S=1 AL, flags from execute = 0110
        step(1'b1, 1'b1, 4'b1010, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b1, 4'd0);
        check("cmp_ctrl", 32'(ALUControl), 32'd1);
        check("cmp_flagw", 32'(FlagW), 32'd3);
        step(1'b0, 1'b0, 4'd0, 1'b0, 4'd14, 1'b0, 1'b0, 1'b1, 4'b0110);
        check("cmp_flags", 32'(flags), 32'b0110);

        // Set Z only, then NE must not execute nor touch flags
        step(1'b1, 1'b1, 4'b1010, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b1, 1'b1, 4'b0100, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 4'b0100);
        check("ne_flags_set", 32'(flags), 32'b0100);
        check("ne_cond_ex", 32'(cond_ex), 32'd0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 4'd14, 1'b0, 1'b0, 1'b1, 4'b1111);
        check("ne_flags_held", 32'(flags), 32'b0100);

        // Back-pressure: 3 stall cycles then back-to-back
        step(1'b1, 1'b1, 4'b0000, 1'b1, 4'b1110, 1'b1, 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 4'b1100, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b1010);
        step(1'b1, 1'b1, 4'b1100, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b1, 4'b1000);
        step(1'b1, 1'b1, 4'b0001, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b1, 4'd0);
        step(1'b1, 1'b1, 4'b1101, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd0);
        step(1'b1, 1'b1, 4'b1011, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b1, 4'b0011);
        step(1'b1, 1'b1, 4'b1000, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b1, 4'b0000);
        idle(1'b1);

        // Illegal cmd and compare-without-S
        step(1'b1, 1'b1, 4'b1111, 1'b1, 4'b1110, 1'b1, 1'b1, 1'b1, 4'd0);
        check("ill_nowrite", 32'(NoWrite), 32'd1);
        check("ill_regw", 32'(reg_write_out), 32'd0);
        step(1'b1, 1'b1, 4'b1010, 1'b0, 4'b1110, 1'b1, 1'b1, 1'b1, 4'd0);
        idle(1'b1);
        check("ill_cnt2", 32'(illegal_cnt), 32'd2);

        // Random traffic
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0), 4'($urandom),
                 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 3) != 0), 4'($urandom));
        idle(1'b1);

        // Saturation
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'b1, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b1, 1'b1, 4'd0);
        idle(1'b1);
        idle(1'b1);
        check("sat_cnt", 32'(illegal_cnt), 32'(CNT_MAX));

        // Reset while FULL drops the request
        step(1'b1, 1'b1, 4'b0100, 1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 4'b1111);
        check("full_before_rst", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_full_valid", 32'(out_valid), 32'd0);
        check("rst_full_flags", 32'(flags), 32'd0);
        check("rst_full_cnt", 32'(illegal_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        m_full = 1'b0; m_flags = 4'b0000; m_cnt = 0;
        idle(1'b1);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
